lt24_pixel_responder: RTL and testbench

Responder end of the LT24 pixel-write interface: it accepts pixel writes (xAddr, yAddr, pixelData, pixelWrite/pixelReady) from application logic and turns them into ILI9341 8080-style bus cycles on the LT24 header. On reset it drives the panel hardware reset and a fixed power-up command list. It then serves pixels, and sends column/page address commands only when a pixel does not directly follow the previous one in raster order.

---
 rtl/lt24_pkg.sv | 56 +++++
 rtl/lt24_init_rom.sv | 30 +++
 rtl/lt24_pixel_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_lt24_pixel_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt24_pkg.sv
// Shared ILI9341 opcodes, pixel-interface state encoding and bus-word helpers
// for the LT24 pixel responder.
package lt24_pkg;

  localparam logic [7:0] CMD_SLEEP_OUT  = 8'h11;
  localparam logic [7:0] CMD_DISPLAY_ON = 8'h29;
  localparam logic [7:0] CMD_COL_ADDR   = 8'h2A;
  localparam logic [7:0] CMD_PAGE_ADDR  = 8'h2B;
  localparam logic [7:0] CMD_MEM_WRITE  = 8'h2C;
  localparam logic [7:0] CMD_PIXEL_FMT  = 8'h3A;
  localparam logic [7:0] PIXFMT_RGB565  = 8'h55;

  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;

  localparam logic [3:0] INIT_LAST = 4'd13;
  localparam logic [3:0] ADDR_LAST = 4'd10;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_INIT_WR,
    ST_SLEEP_WAIT,
    ST_IDLE,
    ST_ADDR_SEQ,
    ST_DATA_WR
  } state_t;

  // {rs, byte} entry of the per-pixel address window sequence
  function automatic logic [8:0] addr_word(input logic [3:0] idx, input logic [7:0] x,
                                           input logic [8:0] y);
    case (idx)
      4'd0:    return {1'b0, CMD_COL_ADDR};
      4'd1:    return {1'b1, 8'h00};
      4'd2:    return {1'b1, x};
      4'd3:    return {1'b1, 8'h00};
      4'd4:    return {1'b1, 8'hEF};
      4'd5:    return {1'b0, CMD_PAGE_ADDR};
      4'd6:    return {1'b1, 7'h00, y[8]};
      4'd7:    return {1'b1, y[7:0]};
      4'd8:    return {1'b1, 8'h01};
      4'd9:    return {1'b1, 8'h3F};
      4'd10:   return {1'b0, CMD_MEM_WRITE};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  // widen a {rs, byte} entry to the {rs, 16-bit data} bus word
  function automatic logic [16:0] bus_word(input logic [8:0] entry);
    return {entry[8], 8'h00, entry[7:0]};
  endfunction

endpackage

// File: rtl/lt24_init_rom.sv
// Power-up command list for the ILI9341: index in, {rs, byte} out.
module lt24_init_rom
  import lt24_pkg::*;
(
  input  logic [3:0] index,
  output logic [8:0] entry
);

  // fixed power-up list: sleep out, pixel format, full-screen window, display on
  always_comb begin
    case (index)
      4'd0:    entry = {1'b0, CMD_SLEEP_OUT};
      4'd1:    entry = {1'b0, CMD_PIXEL_FMT};
      4'd2:    entry = {1'b1, PIXFMT_RGB565};
      4'd3:    entry = {1'b0, CMD_COL_ADDR};
      4'd4:    entry = {1'b1, 8'h00};
      4'd5:    entry = {1'b1, 8'h00};
      4'd6:    entry = {1'b1, 8'h00};
      4'd7:    entry = {1'b1, 8'hEF};
      4'd8:    entry = {1'b0, CMD_PAGE_ADDR};
      4'd9:    entry = {1'b1, 8'h00};
      4'd10:   entry = {1'b1, 8'h00};
      4'd11:   entry = {1'b1, 8'h01};
      4'd12:   entry = {1'b1, 8'h3F};
      4'd13:   entry = {1'b0, CMD_DISPLAY_ON};
      default: entry = {1'b0, 8'h00};
    endcase
  end

endmodule

// File: rtl/lt24_pixel_responder.sv
// LT24 pixel-write responder: panel power-up, then pixel writes as ILI9341
// 8080 bus cycles, skipping the address window for raster-sequential pixels.
module lt24_pixel_responder
  import lt24_pkg::*;
#(
  parameter int WIDTH          = 240,
  parameter int HEIGHT         = 320,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2,
  parameter int RESET_CYCLES   = 500000,
  parameter int SLEEP_CYCLES   = 6000000
) (
  input  logic        clock,
  input  logic        resetApp,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        initDone,
  output logic        LT24Wr_n,
  output logic        LT24Rd_n,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic        LT24Reset_n,
  output logic        LT24LCDOn,
  output logic [15:0] LT24Data
);

  localparam int MAX_WAIT  = (RESET_CYCLES > SLEEP_CYCLES) ? RESET_CYCLES : SLEEP_CYCLES;
  localparam int CNT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int WR_CYCLES = WR_LOW_CYCLES + WR_HIGH_CYCLES;
  localparam int PH_W      = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLEEP_LAST = CNT_W'(SLEEP_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(WR_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_RISE    = PH_W'(WR_LOW_CYCLES - 1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [PH_W-1:0]   phase_r, phase_s, phase_next_s;
  logic [3:0]        idx_r, idx_s, rom_index_s;
  logic [8:0]        rom_entry_s;
  logic [7:0]        x_r, x_s, last_x_r, last_x_s;
  logic [8:0]        y_r, y_s, last_y_r, last_y_s;
  logic [15:0]       pix_r, pix_s;
  logic              last_valid_r, last_valid_s;
  logic              wrn_r, wrn_s, wrn_next_s, csn_r, csn_s, rs_r, rs_s;
  logic [15:0]       data_r, data_s;
  logic              rstn_r, rstn_s, lcd_on_r, lcd_on_s;
  logic              ready_r, ready_s, init_done_r, init_done_s;
  logic              write_end_s, in_range_s, seq_s, load_s;
  logic [16:0]       word_s;

  lt24_init_rom u_init_rom (
    .index (rom_index_s),
    .entry (rom_entry_s)
  );

  // ROM looks ahead one entry while a power-up write is on the bus
  always_comb begin
    rom_index_s = (state_r == ST_INIT_WR) ? (idx_r + 4'd1) : idx_r;
  end

  // write-phase timing and the raster-order test for the offered pixel
  always_comb begin
    write_end_s  = (phase_r == PH_LAST);
    phase_next_s = phase_r + 1'b1;
    wrn_next_s   = (phase_r == PH_RISE) ? 1'b1 : wrn_r;
    in_range_s   = ({1'b0, xAddr} < 9'(WIDTH)) && (yAddr < 9'(HEIGHT));
    seq_s = last_valid_r &&
            ((({1'b0, xAddr} == ({1'b0, last_x_r} + 9'd1)) && (yAddr == last_y_r)) ||
             ((last_x_r == 8'(WIDTH - 1)) && (xAddr == 8'd0) &&
              ({1'b0, yAddr} == ({1'b0, last_y_r} + 10'd1))) ||
             ((last_x_r == 8'(WIDTH - 1)) && (last_y_r == 9'(HEIGHT - 1)) &&
              (xAddr == 8'd0) && (yAddr == 9'd0)));
  end

  // next-state and next-output logic
  always_comb begin
    state_s = state_r;  cnt_s = cnt_r;  phase_s = phase_r;  idx_s = idx_r;
    x_s = x_r;  y_s = y_r;  pix_s = pix_r;
    last_x_s = last_x_r;  last_y_s = last_y_r;  last_valid_s = last_valid_r;
    wrn_s = wrn_r;  csn_s = csn_r;  rs_s = rs_r;  data_s = data_r;
    rstn_s = rstn_r;  lcd_on_s = lcd_on_r;  ready_s = ready_r;  init_done_s = init_done_r;
    load_s = 1'b0;
    word_s = 17'h00000;

    case (state_r)
      ST_RST_LOW: begin
        if (cnt_r == RST_LAST) begin
          rstn_s  = 1'b1;
          cnt_s   = '0;
          state_s = ST_RST_WAIT;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_RST_WAIT: begin
        if (cnt_r == RST_LAST) begin
          cnt_s   = '0;
          state_s = ST_INIT_WR;
          load_s  = 1'b1;
          word_s  = bus_word(rom_entry_s);
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_SLEEP_WAIT: begin
        if (cnt_r == SLEEP_LAST) begin
          cnt_s   = '0;
          state_s = ST_INIT_WR;
          load_s  = 1'b1;
          word_s  = bus_word(rom_entry_s);
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_INIT_WR: begin
        if (!write_end_s) begin
          phase_s = phase_next_s;
          wrn_s   = wrn_next_s;
        end else if (idx_r == 4'd0) begin
          // Sleep Out needs its long settling gap with the bus released
          state_s = ST_SLEEP_WAIT;
          cnt_s   = '0;
          idx_s   = 4'd1;
          csn_s   = 1'b1;
        end else if (idx_r == INIT_LAST) begin
          state_s     = ST_IDLE;
          csn_s       = 1'b1;
          lcd_on_s    = 1'b1;
          init_done_s = 1'b1;
          ready_s     = 1'b1;
        end else begin
          idx_s  = idx_r + 4'd1;
          load_s = 1'b1;
          word_s = bus_word(rom_entry_s);
        end
      end
      ST_IDLE: begin
        if (!ready_r) begin
          ready_s = 1'b1;
        end else if (!pixelWrite) begin
          ready_s = 1'b1;
        end else begin
          ready_s = 1'b0;
          if (!in_range_s) begin
            state_s = ST_IDLE;
          end else begin
            x_s    = xAddr;
            y_s    = yAddr;
            pix_s  = pixelData;
            load_s = 1'b1;
            if (seq_s) begin
              state_s = ST_DATA_WR;
              word_s  = {1'b1, pixelData};
            end else begin
              state_s = ST_ADDR_SEQ;
              idx_s   = 4'd0;
              word_s  = bus_word(addr_word(4'd0, xAddr, yAddr));
            end
          end
        end
      end
      ST_ADDR_SEQ: begin
        if (!write_end_s) begin
          phase_s = phase_next_s;
          wrn_s   = wrn_next_s;
        end else if (idx_r == ADDR_LAST) begin
          state_s = ST_DATA_WR;
          load_s  = 1'b1;
          word_s  = {1'b1, pix_r};
        end else begin
          idx_s  = idx_r + 4'd1;
          load_s = 1'b1;
          word_s = bus_word(addr_word(idx_r + 4'd1, x_r, y_r));
        end
      end
      ST_DATA_WR: begin
        if (!write_end_s) begin
          phase_s = phase_next_s;
          wrn_s   = wrn_next_s;
        end else begin
          state_s      = ST_IDLE;
          csn_s        = 1'b1;
          ready_s      = 1'b1;
          last_x_s     = x_r;
          last_y_s     = y_r;
          last_valid_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_RST_LOW;
        cnt_s   = '0;
      end
    endcase

    if (load_s) begin
      csn_s   = 1'b0;
      wrn_s   = 1'b0;
      phase_s = '0;
      rs_s    = word_s[16];
      data_s  = word_s[15:0];
    end else begin
      rs_s = rs_s;
    end
  end

  // state and registered panel/requester outputs
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state_r <= ST_RST_LOW;  cnt_r <= '0;  phase_r <= '0;  idx_r <= 4'd0;
      x_r <= 8'd0;  y_r <= 9'd0;  pix_r <= 16'h0000;
      last_x_r <= 8'd0;  last_y_r <= 9'd0;  last_valid_r <= 1'b0;
      wrn_r <= 1'b1;  csn_r <= 1'b1;  rs_r <= 1'b1;  data_r <= 16'h0000;
      rstn_r <= 1'b0;  lcd_on_r <= 1'b0;  ready_r <= 1'b0;  init_done_r <= 1'b0;
    end else begin
      state_r <= state_s;  cnt_r <= cnt_s;  phase_r <= phase_s;  idx_r <= idx_s;
      x_r <= x_s;  y_r <= y_s;  pix_r <= pix_s;
      last_x_r <= last_x_s;  last_y_r <= last_y_s;  last_valid_r <= last_valid_s;
      wrn_r <= wrn_s;  csn_r <= csn_s;  rs_r <= rs_s;  data_r <= data_s;
      rstn_r <= rstn_s;  lcd_on_r <= lcd_on_s;  ready_r <= ready_s;  init_done_r <= init_done_s;
    end
  end

  assign pixelReady  = ready_r;
  assign initDone    = init_done_r;
  assign LT24Wr_n    = wrn_r;
  assign LT24Rd_n    = 1'b1;
  assign LT24CS_n    = csn_r;
  assign LT24RS      = rs_r;
  assign LT24Reset_n = rstn_r;
  assign LT24LCDOn   = lcd_on_r;
  assign LT24Data    = data_r;

endmodule

// File: tb/tb_lt24_pixel_responder.sv
// Scoreboard bench: stimulus pushes expected bus words from a raster-order
// reference model; a bus monitor pops and compares every write it observes.
module tb_lt24_pixel_responder;
  import lt24_pkg::*;

  localparam int W   = 240;
  localparam int H   = 320;
  localparam int WRL = 2;
  localparam int WRH = 2;
  localparam int RC  = 4;
  localparam int SC  = 8;
  localparam int WRC = WRL + WRH;

  logic        clock, resetApp, pixelWrite;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelReady, initDone, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24LCDOn;
  logic [15:0] LT24Data;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [16:0] exp_q[$];
  int          start_cyc[$];
  int          m_lx = 0;
  int          m_ly = 0;
  bit          m_valid = 1'b0;

  lt24_pixel_responder #(
    .WIDTH(W), .HEIGHT(H), .WR_LOW_CYCLES(WRL), .WR_HIGH_CYCLES(WRH),
    .RESET_CYCLES(RC), .SLEEP_CYCLES(SC)
  ) dut (
    .clock(clock), .resetApp(resetApp), .xAddr(xAddr), .yAddr(yAddr),
    .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .initDone(initDone), .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n), .LT24CS_n(LT24CS_n),
    .LT24RS(LT24RS), .LT24Reset_n(LT24Reset_n), .LT24LCDOn(LT24LCDOn), .LT24Data(LT24Data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_word(input bit rs, input int b);
    logic [16:0] w;
    w = {rs, 16'(b)};
    exp_q.push_back(w);
  endfunction

  function automatic void successor(output int nx, output int ny);
    if (m_lx + 1 < W) begin
      nx = m_lx + 1;
      ny = m_ly;
    end else begin
      nx = 0;
      ny = (m_ly + 1) % H;
    end
  endfunction

  // reference model: queue the expected bus words, return expected pixelReady latency
  function automatic int model_pixel(input int x, input int y, input int d);
    int nx, ny;
    bit seq;
    if (x >= W || y >= H) return 2;
    successor(nx, ny);
    seq = m_valid && (x == nx) && (y == ny);
    if (!seq) begin
      push_word(1'b0, 'h2A); push_word(1'b1, 0); push_word(1'b1, x);
      push_word(1'b1, 0);    push_word(1'b1, W - 1);
      push_word(1'b0, 'h2B); push_word(1'b1, y / 256); push_word(1'b1, y % 256);
      push_word(1'b1, (H - 1) / 256); push_word(1'b1, (H - 1) % 256);
      push_word(1'b0, 'h2C);
    end
    push_word(1'b1, d);
    m_lx = x;
    m_ly = y;
    m_valid = 1'b1;
    return seq ? (1 + WRC) : (1 + 12 * WRC);
  endfunction

  // bus monitor: every falling LT24Wr_n is one write checked against the scoreboard
  initial begin
    bit          prev_wr;
    int          low_run;
    logic [16:0] cur;
    prev_wr = 1'b1;
    low_run = 0;
    cur     = 17'h0;
    forever begin
      @(negedge clock);
      cyc++;
      if (LT24Wr_n === 1'b0) begin
        if (prev_wr) begin
          start_cyc.push_back(cyc);
          cur     = {LT24RS, LT24Data};
          low_run = 1;
          chk("cs_low_during_write", LT24CS_n, 1'b0);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got rs=%0b data=0x%0h, expected no write", LT24RS, LT24Data);
          end else begin
            chk("bus_word", cur, exp_q.pop_front());
          end
        end else begin
          low_run++;
          chk("bus_stable", {LT24RS, LT24Data}, cur);
        end
      end else if (!prev_wr) begin
        chk("wr_low_cycles", low_run, WRL);
      end
      prev_wr = (LT24Wr_n !== 1'b0);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_reset_n"}, LT24Reset_n, 1'b0);
    chk({tag, "_cs_n"}, LT24CS_n, 1'b1);
    chk({tag, "_wr_n"}, LT24Wr_n, 1'b1);
    chk({tag, "_rd_n"}, LT24Rd_n, 1'b1);
    chk({tag, "_rs"}, LT24RS, 1'b1);
    chk({tag, "_data"}, LT24Data, 16'h0000);
    chk({tag, "_lcd_on"}, LT24LCDOn, 1'b0);
    chk({tag, "_ready"}, pixelReady, 1'b0);
    chk({tag, "_init_done"}, initDone, 1'b0);
  endtask

  // power-up with a pixel already offered; returns at the negedge initDone is seen
  task automatic run_init(input int x, input int y, input int d);
    int n;
    bit bad;
    resetApp = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_vals("held_reset");
    xAddr = 8'(x); yAddr = 9'(y); pixelData = 16'(d); pixelWrite = 1'b1;
    start_cyc.delete();
    m_valid = 1'b0;
    push_word(1'b0, 'h11); push_word(1'b0, 'h3A); push_word(1'b1, 'h55);
    push_word(1'b0, 'h2A); push_word(1'b1, 'h00); push_word(1'b1, 'h00);
    push_word(1'b1, 'h00); push_word(1'b1, 'hEF);
    push_word(1'b0, 'h2B); push_word(1'b1, 'h00); push_word(1'b1, 'h00);
    push_word(1'b1, 'h01); push_word(1'b1, 'h3F); push_word(1'b0, 'h29);
    resetApp = 1'b0;
    n = 0;
    while (!LT24Reset_n && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("reset_low_cycles", n, RC);
    n = 0;
    bad = 1'b0;
    while (!initDone && n < 2000) begin
      if (pixelReady) bad = 1'b1;
      @(negedge clock);
      n++;
    end
    chk("init_done_seen", initDone, 1'b1);
    chk("ready_low_during_init", bad, 1'b0);
    chk("ready_with_init_done", pixelReady, 1'b1);
    chk("lcd_on_after_init", LT24LCDOn, 1'b1);
    chk("cs_high_after_init", LT24CS_n, 1'b1);
    chk("init_words_consumed", exp_q.size(), 0);
    chk("init_write_count", start_cyc.size(), 14);
    if (start_cyc.size() >= 2) chk("sleep_gap", start_cyc[1] - start_cyc[0], WRC + SC);
  endtask

  // offer one pixel; called at a negedge, returns at the negedge pixelReady is back
  task automatic issue(input int x, input int y, input int d, input bit keep);
    int n, lat, exp_lat;
    xAddr = 8'(x); yAddr = 9'(y); pixelData = 16'(d); pixelWrite = 1'b1;
    n = 0;
    while (!pixelReady && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!pixelReady) begin
      chk("ready_wait_timeout", pixelReady, 1'b1);
      pixelWrite = 1'b0;
    end else begin
      exp_lat = model_pixel(x, y, d);
      @(negedge clock);
      lat = 1;
      if (!keep) pixelWrite = 1'b0;
      while (!pixelReady && lat < 200) begin
        @(negedge clock);
        lat++;
      end
      chk($sformatf("ready_latency_%0d_%0d", x, y), lat, exp_lat);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int sx, sy, n;
    resetApp = 1'b1; pixelWrite = 1'b0; xAddr = 8'd0; yAddr = 9'd0; pixelData = 16'h0000;

    run_init(10, 20, 'hF800);
    issue(10, 20, 'hF800, 1'b0);

    // raster stream with pixelWrite held high, including both wrap points
    issue(0, 0, RGB_RED, 1'b1);
    for (int i = 1; i <= 5; i++) issue(i, 0, RGB_GREEN + i, 1'b1);
    issue(238, 0, RGB_BLUE, 1'b1);
    issue(239, 0, RGB_WHITE, 1'b1);
    issue(0, 1, RGB_BLACK, 1'b1);
    issue(238, 319, 'h1234, 1'b1);
    issue(239, 319, 'h5678, 1'b1);
    issue(0, 0, 'h9ABC, 1'b0);

    // out of range is discarded; last position stays (0,0)
    issue(240, 5, 'hDEAD, 1'b0);
    issue(0, 0, 'hBEEF, 1'b0);

    for (int i = 0; i < 30; i++) begin
      int r, x, y;
      r = $urandom_range(0, 9);
      if (r < 5 && m_valid) begin
        successor(x, y);
      end else if (r < 7) begin
        x = $urandom_range(0, W - 1);
        y = $urandom_range(0, H - 1);
      end else if (r == 7) begin
        x = $urandom_range(W, 255);
        y = $urandom_range(0, 511);
      end else if (r == 8) begin
        x = $urandom_range(0, W - 1);
        y = $urandom_range(H, 511);
      end else begin
        x = m_lx;
        y = m_ly;
      end
      issue(x, y, $urandom_range(0, 65535), 1'($urandom_range(0, 1)));
    end
    drain();

    // reset in the middle of an address sequence (repeating the last pixel is never sequential)
    xAddr = 8'(m_lx); yAddr = 9'(m_ly); pixelData = 16'h0F0F; pixelWrite = 1'b1;
    n = 0;
    while (!pixelReady && n < 200) begin
      @(negedge clock);
      n++;
    end
    push_word(1'b0, 'h2A); push_word(1'b1, 0); push_word(1'b1, m_lx);
    @(negedge clock);
    pixelWrite = 1'b0;
    repeat (11) @(negedge clock);
    chk("partial_addr_seq_seen", exp_q.size(), 0);
    #2 resetApp = 1'b1;
    #1 check_reset_vals("async_reset");
    successor(sx, sy);
    run_init(sx, sy, 'h0BAD);
    issue(sx, sy, 'h0BAD, 1'b0);
    successor(sx, sy);
    issue(sx, sy, 'h0ACE, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
